// File: rtl/pad_arb_pkg.sv
// rtl/pad_arb_pkg.sv - shared types and pad-word field helpers for the pad output arbiter
package pad_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HOLD  = 2'd2
    } pad_state_e;

    // Source-ID width; a 1-bit ID is kept even for degenerate requester counts.
    function automatic int pad_src_w(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

    function automatic int pad_payload_w(input int num_pads, input int num_req);
        return num_pads - 1 - pad_src_w(num_req);
    endfunction

    function automatic int pad_strobe_pos(input int num_pads);
        return num_pads - 1;
    endfunction

    // The ID field sits directly above the payload.
    function automatic int pad_id_lsb(input int num_pads, input int num_req);
        return pad_payload_w(num_pads, num_req);
    endfunction

    function automatic int pad_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin select starting just after last_grant
module rr_arbiter
    import pad_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = pad_src_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [SRC_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [SRC_W-1:0]   grant_idx_o,
    output logic               any_o
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = SRC_W'((int'(last_grant_i) + i) % NUM_REQ);
            if (!any_o && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pad_output_arbiter.sv
// rtl/pad_output_arbiter.sv - round-robin share of the output pad bus with setup/hold timed strobe
module pad_output_arbiter
    import pad_arb_pkg::*;
#(
    parameter int NUM_OUTPUT_PADS = 32,
    parameter int NUM_REQ         = 4,
    parameter int SETUP_CYCLES    = 2,
    parameter int HOLD_CYCLES     = 4,
    localparam int SRC_W          = pad_src_w(NUM_REQ),
    localparam int PAYLOAD_W      = NUM_OUTPUT_PADS - 1 - SRC_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_OUTPUT_PADS-1:0]     output_out,
    output logic                           busy
);

    localparam int STROBE_POS = pad_strobe_pos(NUM_OUTPUT_PADS);
    localparam int ID_LSB     = pad_id_lsb(NUM_OUTPUT_PADS, NUM_REQ);
    localparam int CNT_W      = $clog2(pad_max(SETUP_CYCLES, HOLD_CYCLES) + 1);

    pad_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SRC_W-1:0]           last_grant_q, last_grant_d;
    logic [NUM_OUTPUT_PADS-1:0] out_q, out_d;

    logic [NUM_REQ-1:0]         grant_oh;
    logic [SRC_W-1:0]           grant_idx;
    logic                       grant_any;
    logic [PAYLOAD_W-1:0]       sel_payload;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_oh),
        .grant_idx_o  (grant_idx),
        .any_o        (grant_any)
    );

    assign sel_payload = req_data[int'(grant_idx)*PAYLOAD_W +: PAYLOAD_W];

    // Ready depends only on state and valid so requesters see no data-to-ready path.
    assign req_ready  = (state_q == ST_IDLE) ? grant_oh : '0;
    assign busy       = (state_q != ST_IDLE);
    assign output_out = out_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        out_d        = out_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    out_d[ID_LSB +: SRC_W]  = grant_idx;
                    out_d[0 +: PAYLOAD_W]   = sel_payload;
                    last_grant_d            = grant_idx;
                    cnt_d                   = CNT_W'(SETUP_CYCLES - 1);
                    state_d                 = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    out_d[STROBE_POS] = ~out_q[STROBE_POS];
                    cnt_d             = CNT_W'(HOLD_CYCLES - 1);
                    state_d           = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            out_q        <= out_d;
        end
    end

endmodule

// File: tb/tb_pad_output_arbiter.sv
// tb/tb_pad_output_arbiter.sv - directed self-checking bench for pad_output_arbiter
module tb_pad_output_arbiter;

    localparam int NP = 32;
    localparam int NR = 4;
    localparam int PW = 29;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR*PW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic [NP-1:0]      output_out;
    logic               busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_strobe;

    pad_output_arbiter #(
        .NUM_OUTPUT_PADS (NP),
        .NUM_REQ         (NR),
        .SETUP_CYCLES    (2),
        .HOLD_CYCLES     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .output_out (output_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic s, input logic [1:0] id, input logic [28:0] p);
        return {s, id, p};
    endfunction

    task automatic set_data(input int id, input logic [28:0] v);
        req_data[id*PW +: PW] = v;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        exp_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Entered at the start of the IDLE cycle in which a grant to id is expected;
    // returns at the start of the IDLE cycle that follows the word.
    task automatic serve(input logic [1:0] id, input logic [28:0] pl, input bit drop);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << id;
        @(negedge clk);
        check("grant_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        check("idle_busy", {31'd0, busy}, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1 && drop) req_valid[id] = 1'b0;
            if (c == 3) exp_strobe = ~exp_strobe;
            @(negedge clk);
            check("pads", output_out, mk(exp_strobe, id, pl));
            check("word_busy", {31'd0, busy}, 32'd1);
            check("word_ready", {28'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        exp_strobe = 1'b0;

        // Reset state and quiet idle
        #3;
        check("reset_pads", output_out, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("quiet_pads", output_out, 32'd0);
            check("quiet_busy", {31'd0, busy}, 32'd0);
            check("quiet_ready", {28'd0, req_ready}, 32'd0);
        end

        // Single request on requester 2
        @(posedge clk); #1;
        set_data(2, 29'h1ABCDEF);
        req_valid = 4'b0100;
        serve(2'd2, 29'h1ABCDEF, 1'b1);
        @(negedge clk);
        check("single_c7_busy", {31'd0, busy}, 32'd0);
        check("single_c7_pads", output_out, 32'hC1ABCDEF);
        check("single_c7_ready", {28'd0, req_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("single_held", output_out, 32'hC1ABCDEF);

        // All four valid continuously: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) set_data(i, 29'h100 + 29'(i));
        req_valid = 4'b1111;
        serve(2'd0, 29'h100, 1'b0);
        serve(2'd1, 29'h101, 1'b0);
        serve(2'd2, 29'h102, 1'b0);
        serve(2'd3, 29'h103, 1'b0);
        serve(2'd0, 29'h100, 1'b0);
        check("five_toggles", {31'd0, output_out[31]}, 32'd1);

        // Pointer fairness: after a grant to 1, 3 beats 0
        req_valid = 4'b0010;
        serve(2'd1, 29'h101, 1'b1);
        req_valid = 4'b1001;
        serve(2'd3, 29'h103, 1'b1);
        serve(2'd0, 29'h100, 1'b1);
        @(negedge clk);
        check("fair_idle_ready", {28'd0, req_ready}, 32'd0);

        // Back-to-back words on requester 1; strobe 1,0,1
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 29'h1);
        serve(2'd1, 29'h1, 1'b0);
        check("b2b_strobe1", {31'd0, output_out[31]}, 32'd1);
        set_data(1, 29'h2);
        serve(2'd1, 29'h2, 1'b0);
        check("b2b_strobe2", {31'd0, output_out[31]}, 32'd0);
        set_data(1, 29'h3);
        serve(2'd1, 29'h3, 1'b1);
        check("b2b_strobe3", {31'd0, output_out[31]}, 32'd1);

        // Reset in the second HOLD cycle of requester 2's second word
        do_reset();
        req_valid = 4'b0100;
        set_data(0, 29'h0123456);
        set_data(2, 29'h0AAAAAA);
        serve(2'd2, 29'h0AAAAAA, 1'b0);
        set_data(2, 29'h0555555);
        @(negedge clk);
        check("mid_ready", {28'd0, req_ready}, 32'h4);
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mid_hold2_pads", output_out, mk(1'b0, 2'd2, 29'h0555555));
        #1 rst_n = 1'b0;
        #1;
        check("async_pads", output_out, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        req_valid  = 4'b0101;
        exp_strobe = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        serve(2'd0, 29'h0123456, 1'b1);
        req_valid = '0;
        @(negedge clk);
        check("post_reset_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
